// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: prescaler plus rotate/bounce/fill-drain pattern register.
// Optional LED_SPEED_SEL_EN adds a speed[1:0] post-divider (step every 2^speed prescaler periods).
module led_pattern_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef LED_SPEED_SEL_EN
    input  logic [1:0]       speed,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned    PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [PW-1:0]    presc;
    logic             dir_left;
    logic             phase_fill;
    logic             presc_wrap;
    logic             step_due;

    logic [WIDTH-1:0] nxt_out;
    logic             nxt_wrap;
    logic             nxt_dir_left;
    logic             nxt_phase_fill;
    logic             eff_fill;

    assign presc_wrap = en && (presc == PRESC_MAX);

`ifdef LED_SPEED_SEL_EN
    logic [2:0] post_cnt;
    logic [2:0] post_lim;
    logic [1:0] speed_q;
    logic       speed_chg;

    assign speed_chg = (speed != speed_q);
    assign post_lim  = 3'((4'd1 << speed) - 4'd1);
    // A speed change restarts the post-count, so that edge sees a count of zero.
    assign step_due  = presc_wrap && (speed_chg ? (speed == 2'd0) : (post_cnt == post_lim));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            post_cnt <= 3'd0;
            speed_q  <= 2'd0;
        end else begin
            speed_q <= speed;
            if (load || speed_chg)
                post_cnt <= 3'd0;
            else if (presc_wrap)
                post_cnt <= step_due ? 3'd0 : post_cnt + 3'd1;
        end
    end
`else
    assign step_due = presc_wrap;
`endif

    // Next pattern for a step in the current mode.
    always_comb begin
        nxt_out        = out;
        nxt_wrap       = 1'b0;
        nxt_dir_left   = dir_left;
        nxt_phase_fill = phase_fill;
        eff_fill       = phase_fill;
        case (mode)
            2'b00: begin
                nxt_out  = {out[WIDTH-2:0], out[WIDTH-1]};
                nxt_wrap = out[WIDTH-1];
            end
            2'b01: begin
                nxt_out  = {out[0], out[WIDTH-1:1]};
                nxt_wrap = out[0];
            end
            2'b10: begin
                if ($onehot(out)) begin
                    if (dir_left) begin
                        if (out[WIDTH-1]) begin
                            nxt_out      = out >> 1;
                            nxt_dir_left = 1'b0;
                            nxt_wrap     = 1'b1;
                        end else begin
                            nxt_out = out << 1;
                        end
                    end else begin
                        if (out[0]) begin
                            nxt_out      = out << 1;
                            nxt_dir_left = 1'b1;
                            nxt_wrap     = 1'b1;
                        end else begin
                            nxt_out = out >> 1;
                        end
                    end
                end else begin
                    nxt_out      = ONE;
                    nxt_dir_left = 1'b1;
                end
            end
            default: begin
                // A saturated pattern flips phase before shifting.
                eff_fill = phase_fill ? (out != ALL_ONES) : (out == '0);
                nxt_out  = {out[WIDTH-2:0], eff_fill};
                nxt_phase_fill = eff_fill;
                if (eff_fill && (nxt_out == ALL_ONES)) begin
                    nxt_phase_fill = 1'b0;
                    nxt_wrap       = 1'b1;
                end else if (!eff_fill && (nxt_out == '0)) begin
                    nxt_phase_fill = 1'b1;
                    nxt_wrap       = 1'b1;
                end
            end
        endcase
    end

    // Prescaler, pattern register and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= ONE;
            tick       <= 1'b0;
            wrap       <= 1'b0;
            presc      <= '0;
            dir_left   <= 1'b1;
            phase_fill <= 1'b1;
        end else if (load) begin
            out        <= load_val;
            tick       <= 1'b0;
            wrap       <= 1'b0;
            presc      <= '0;
            dir_left   <= 1'b1;
            phase_fill <= 1'b1;
        end else begin
            tick <= step_due;
            wrap <= step_due && nxt_wrap;
            if (en)
                presc <= presc_wrap ? '0 : presc + PW'(1);
            if (step_due) begin
                out        <= nxt_out;
                dir_left   <= nxt_dir_left;
                phase_fill <= nxt_phase_fill;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at WIDTH = 8, DIV = 4.
module tb_led_pattern_gen;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    localparam logic [7:0] BSEQ [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    localparam logic [7:0] FSEQ [17] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                         8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                                         8'h01, 8'h03};

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
`ifdef LED_SPEED_SEL_EN
    logic [1:0]   speed;
`endif
    logic [W-1:0] out;
    logic         tick;
    logic         wrap;

    int n_vec = 0;
    int n_err = 0;

    led_pattern_gen #(.WIDTH(W), .DIV(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
`ifdef LED_SPEED_SEL_EN
        .speed    (speed),
`endif
        .out      (out),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; release just after an edge so the prescaler starts at 0.
    task automatic apply_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        reset    = 1'b1;
        en       = 1'b1;
        mode     = 2'b00;
        load     = 1'b0;
        load_val = '0;
`ifdef LED_SPEED_SEL_EN
        speed    = 2'd0;
`endif
        cyc(2);
        reset = 1'b0;
        check("rst_out", 32'(out), 32'h01);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);

        // rotate left: 8 ticks bring the dot back with wrap on the last one
        for (int i = 1; i <= 8; i++) begin
            cyc(3);
            check("rol_idle", 32'(tick), 32'h0);
            cyc(1);
            e = 8'(1 << (i % 8));
            check("rol_out", 32'(out), 32'(e));
            check("rol_tick", 32'(tick), 32'h1);
            check("rol_wrap", 32'(wrap), 32'((i == 8) ? 1 : 0));
        end

        // bounce
        mode = 2'b10;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(4);
            check("bnc_out", 32'(out), 32'(BSEQ[i]));
            check("bnc_wrap", 32'(wrap), 32'((i == 7 || i == 14) ? 1 : 0));
        end

        // fill / drain
        mode = 2'b11;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(4);
            check("fd_out", 32'(out), 32'(FSEQ[i]));
            check("fd_wrap", 32'(wrap), 32'((i == 6 || i == 14) ? 1 : 0));
        end

        // load colliding with a due step in rotate-right
        mode = 2'b01;
        apply_reset();
        cyc(3);
        load     = 1'b1;
        load_val = 8'hA5;
        cyc(1);
        load = 1'b0;
        check("ld_out", 32'(out), 32'hA5);
        check("ld_tick", 32'(tick), 32'h0);
        check("ld_wrap", 32'(wrap), 32'h0);
        cyc(3);
        check("ld_idle", 32'(tick), 32'h0);
        cyc(1);
        check("ror_out", 32'(out), 32'hD2);
        check("ror_tick", 32'(tick), 32'h1);
        check("ror_wrap", 32'(wrap), 32'h1);

        // freeze with prescaler mid-count
        cyc(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("frz_tick", 32'(tick), 32'h0);
            check("frz_out", 32'(out), 32'hD2);
        end
        en = 1'b1;
        cyc(1);
        check("unfrz_idle", 32'(tick), 32'h0);
        cyc(1);
        check("unfrz_out", 32'(out), 32'h69);
        check("unfrz_tick", 32'(tick), 32'h1);
        check("unfrz_wrap", 32'(wrap), 32'h0);

        // load while disabled
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h33;
        cyc(1);
        load = 1'b0;
        check("ld_dis_out", 32'(out), 32'h33);
        en = 1'b1;

        // asynchronous reset while out = 0x40 and tick high
        mode     = 2'b00;
        load     = 1'b1;
        load_val = 8'h20;
        cyc(1);
        load = 1'b0;
        cyc(4);
        check("pre_rst_out", 32'(out), 32'h40);
        check("pre_rst_tick", 32'(tick), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'h01);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_wrap", 32'(wrap), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef LED_SPEED_SEL_EN
        // speed = 2: step every 16 clocks; a speed change restarts the post-count
        speed = 2'd2;
        mode  = 2'b00;
        apply_reset();
        cyc(15);
        check("spd_idle", 32'(tick), 32'h0);
        cyc(1);
        check("spd_tick", 32'(tick), 32'h1);
        check("spd_out", 32'(out), 32'h02);
        cyc(6);
        speed = 2'd1;
        cyc(2);
        check("spd_restart_idle", 32'(tick), 32'h0);
        cyc(4);
        check("spd_restart_tick", 32'(tick), 32'h1);
        check("spd_restart_out", 32'(out), 32'h04);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
